// File: rtl/mvm_uart_pkg.sv
// Shared widths, derived bus sizes and FSM state types for the UART-MVM frame controller.
package mvm_uart_pkg;

  localparam int unsigned R             = 2;
  localparam int unsigned C             = 2;
  localparam int unsigned W_X           = 4;
  localparam int unsigned W_K           = 4;
  localparam int unsigned W_Y_OUT       = 8;
  localparam int unsigned BITS_PER_WORD = 8;
  localparam int unsigned TIMEOUT_CYC   = 4340;

  localparam int unsigned W_BUS_KX   = R * C * W_K + C * W_X;
  localparam int unsigned W_BUS_Y    = R * W_Y_OUT;
  localparam int unsigned N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int unsigned N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

  typedef enum logic {IDLE, ISSUE} issue_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

endpackage

// File: rtl/mvm_word_serializer.sv
// Captures a wide bus on a valid/ready handshake and emits it LSB word first,
// accepting the next bus on the same cycle the last word is taken.
module mvm_word_serializer
  import mvm_uart_pkg::*;
#(
  parameter int unsigned W_BUS  = W_BUS_Y,
  parameter int unsigned W_WORD = BITS_PER_WORD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_BUS-1:0]  i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_WORD-1:0] o_data
);

  localparam int unsigned N_WORDS = W_BUS / W_WORD;
  localparam int unsigned W_IDX   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  tx_state_t          r_state, w_state_nx;
  logic [W_BUS-1:0]   r_buf, w_buf_nx, w_shift;
  logic [W_IDX-1:0]   r_j, w_j_nx;
  logic               r_live;
  logic               w_last, w_hs, w_cap;

  // r_live keeps o_ready low while in reset and on the first cycle after it
  assign o_valid = (r_state == TX_SEND);
  assign w_last  = (r_j == W_IDX'(N_WORDS - 1));
  assign w_hs    = o_valid && i_ready;
  assign o_ready = r_live && (!o_valid || (w_last && w_hs));
  assign w_cap   = i_valid && o_ready;
  assign w_shift = r_buf >> (W_WORD * 32'(r_j));
  assign o_data  = w_shift[W_WORD-1:0];

  always_comb begin
    w_state_nx = r_state;
    w_buf_nx   = r_buf;
    w_j_nx     = r_j;
    case (r_state)
      TX_IDLE: begin
        if (w_cap) begin
          w_state_nx = TX_SEND;
          w_buf_nx   = i_data;
          w_j_nx     = '0;
        end
      end
      TX_SEND: begin
        if (w_cap) begin
          w_buf_nx = i_data;
          w_j_nx   = '0;
        end else if (w_hs) begin
          if (w_last) begin
            w_state_nx = TX_IDLE;
            w_j_nx     = '0;
          end else begin
            w_j_nx = r_j + 1'b1;
          end
        end
      end
      default: w_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= TX_IDLE;
      r_buf   <= '0;
      r_j     <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_buf   <= w_buf_nx;
      r_j     <= w_j_nx;
      r_live  <= 1'b1;
    end
  end

endmodule

// File: rtl/mvm_uart_ctrl.sv
// Frame controller: assembles UART words into the MVM operand bus and serialises
// MVM results back into UART words, with an idle timeout on partial frames.
module mvm_uart_ctrl
  import mvm_uart_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx_valid,
  input  logic [BITS_PER_WORD-1:0] rx_data,
  output logic                     kx_valid,
  input  logic                     kx_ready,
  output logic [W_BUS_KX-1:0]      kx_data,
  input  logic                     y_valid,
  output logic                     y_ready,
  input  logic [W_BUS_Y-1:0]       y_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [BITS_PER_WORD-1:0] tx_data,
  output logic                     overrun,
  output logic                     frame_abort
);

  localparam int unsigned W_IDX_KX = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
  localparam int unsigned W_TMO    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  issue_state_t          r_istate, w_istate_nx;
  logic [W_BUS_KX-1:0]   r_rx_buf, w_rx_buf_nx, r_kx_data;
  logic [W_IDX_KX-1:0]   r_i, w_idx, w_i_nx;
  logic [W_TMO-1:0]      r_tmo;
  logic                  r_overrun, r_abort;
  logic                  w_overrun, w_load, w_done, w_tmo_hit, w_kx_hs;

  assign kx_valid    = (r_istate == ISSUE);
  assign kx_data     = r_kx_data;
  assign overrun     = r_overrun;
  assign frame_abort = r_abort;
  assign w_kx_hs     = kx_valid && kx_ready;
  assign w_tmo_hit   = (TIMEOUT_CYC != 0) && (r_i != '0) && (r_tmo == W_TMO'(TIMEOUT_CYC));

  // A word arriving on the abort cycle restarts the frame at word 0
  always_comb begin
    w_idx       = w_tmo_hit ? '0 : r_i;
    w_rx_buf_nx = r_rx_buf;
    for (int unsigned w = 0; w < N_WORDS_KX; w++) begin
      if (rx_valid && (w_idx == W_IDX_KX'(w))) begin
        w_rx_buf_nx[w*BITS_PER_WORD +: BITS_PER_WORD] = rx_data;
      end
    end
    w_done = rx_valid && (w_idx == W_IDX_KX'(N_WORDS_KX - 1));
    if (w_done) begin
      w_i_nx = '0;
    end else if (rx_valid) begin
      w_i_nx = w_idx + 1'b1;
    end else begin
      w_i_nx = w_idx;
    end
  end

  always_comb begin
    w_istate_nx = r_istate;
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    case (r_istate)
      IDLE: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_istate_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (w_kx_hs) begin
          if (w_done) begin
            w_load = 1'b1;
          end else begin
            w_istate_nx = IDLE;
          end
        end else if (w_done) begin
          w_overrun = 1'b1;
        end
      end
      default: w_istate_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_istate <= IDLE;
    end else begin
      r_istate <= w_istate_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_buf  <= '0;
      r_kx_data <= '0;
      r_i       <= '0;
      r_tmo     <= '0;
      r_overrun <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_rx_buf  <= w_rx_buf_nx;
      r_i       <= w_i_nx;
      r_overrun <= w_overrun;
      r_abort   <= w_tmo_hit;
      if (w_load) begin
        r_kx_data <= w_rx_buf_nx;
      end
      if (rx_valid || (r_i == '0) || w_tmo_hit) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  mvm_word_serializer #(
    .W_BUS  (W_BUS_Y),
    .W_WORD (BITS_PER_WORD)
  ) u_tx_ser (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (y_valid),
    .o_ready (y_ready),
    .i_data  (y_data),
    .o_valid (tx_valid),
    .i_ready (tx_ready),
    .o_data  (tx_data)
  );

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Directed and random checks of mvm_uart_ctrl against a stub MVM and an
// arithmetic reference model of the 2x2 matrix-vector product.
module tb_mvm_uart_ctrl;
  import mvm_uart_pkg::*;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     rx_valid;
  logic [BITS_PER_WORD-1:0] rx_data;
  logic                     kx_valid;
  logic                     kx_ready;
  logic [W_BUS_KX-1:0]      kx_data;
  logic                     y_valid = 1'b0;
  logic                     y_ready;
  logic [W_BUS_Y-1:0]       y_data = '0;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [BITS_PER_WORD-1:0] tx_data;
  logic                     overrun;
  logic                     frame_abort;

  int n_vec = 0;
  int n_err = 0;
  int n_ovr = 0;
  int n_abort = 0;

  logic [7:0]          tx_q[$];
  logic [7:0]          exp_q[$];
  logic [W_BUS_KX-1:0] kx_q[$];
  logic [W_BUS_KX-1:0] fr_q[$];
  logic [W_BUS_Y-1:0]  y_q[$];

  logic [W_BUS_KX-1:0] fa, fb, fc;
  logic [W_BUS_Y-1:0]  ya;
  int o0, ab0, bad, cnt;

  always #5 clk = ~clk;

  mvm_uart_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .kx_valid    (kx_valid),
    .kx_ready    (kx_ready),
    .kx_data     (kx_data),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .y_data      (y_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .overrun     (overrun),
    .frame_abort (frame_abort)
  );

  function automatic int nib(input logic [W_BUS_KX-1:0] bus, input int i);
    int v;
    v = int'((bus >> (4 * i)) & 24'hF);
    return (v > 7) ? v - 16 : v;
  endfunction

  // y[r] = sum_c k[r][c]*x[c] mod 256, X in the low nibbles, then k row-major above it
  function automatic logic [W_BUS_Y-1:0] model_y(input logic [W_BUS_KX-1:0] bus);
    logic [W_BUS_Y-1:0] y;
    int acc;
    y = '0;
    for (int r = 0; r < 2; r++) begin
      acc = 0;
      for (int c = 0; c < 2; c++) acc += nib(bus, 2 + 2 * r + c) * nib(bus, c);
      y[8*r +: 8] = 8'(acc);
    end
    return y;
  endfunction

  // Stub MVM and monitors sample at the active edge, stub drives on the falling edge
  always @(posedge clk) begin
    if (!rstn) begin
      y_q.delete();
    end else begin
      if (y_valid && y_ready && y_q.size() > 0) y_q.delete(0);
      if (kx_valid && kx_ready) begin
        y_q.push_back(model_y(kx_data));
        kx_q.push_back(kx_data);
      end
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (overrun) n_ovr++;
      if (frame_abort) n_abort++;
    end
  end

  always @(negedge clk) begin
    y_valid = rstn && (y_q.size() > 0);
    y_data  = (y_q.size() > 0) ? y_q[0] : '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W_BUS_KX-1:0] f);
    for (int i = 0; i < 3; i++) send_byte(f[8*i +: 8]);
  endtask

  task automatic push_exp(input logic [W_BUS_KX-1:0] f);
    logic [W_BUS_Y-1:0] y;
    y = model_y(f);
    exp_q.push_back(y[7:0]);
    exp_q.push_back(y[15:8]);
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, tx_q.size(), n);
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_count"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < tx_q.size()) check($sformatf("%s_w%0d", tag, i), tx_q[i], exp_q[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_kx_valid"}, kx_valid, 0);
    check({tag, "_kx_data"}, kx_data, 0);
    check({tag, "_y_ready"}, y_ready, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_frame_abort"}, frame_abort, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; kx_ready = 1'b1; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 1: directed frame and latencies
    tx_q.delete(); exp_q.delete();
    send_byte(8'h65); send_byte(8'h21);
    check("t1_kx_valid_early", kx_valid, 0);
    send_byte(8'h43);
    check("t1_kx_valid", kx_valid, 1);
    check("t1_kx_data", kx_data, 24'h432165);
    @(negedge clk); @(negedge clk);
    check("t1_tx_valid", tx_valid, 1);
    check("t1_tx_first", tx_data, 8'h11);
    wait_tx(2, 50, "t1_tx_wait");
    exp_q.push_back(8'h11); exp_q.push_back(8'h27);
    compare_tx("t1");

    // 2: TX back-pressure with a second result waiting
    tx_q.delete(); exp_q.delete(); tx_ready = 1'b0;
    fa = 24'($urandom); fb = 24'($urandom);
    ya = model_y(fa);
    push_exp(fa); push_exp(fb);
    send_frame(fa);
    cnt = 0;
    while (!tx_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check("t2_tx_valid", tx_valid, 1);
    send_frame(fb);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_data !== ya[7:0] || y_ready !== 1'b0 || tx_valid !== 1'b1) bad++;
    end
    check("t2_hold_cycles_bad", bad, 0);
    check("t2_none_sent", tx_q.size(), 0);
    tx_ready = 1'b1;
    wait_tx(4, 50, "t2_tx_wait");
    compare_tx("t2");

    // 3: operand back-pressure causes overrun
    tx_q.delete(); exp_q.delete(); kx_q.delete();
    kx_ready = 1'b0; o0 = n_ovr;
    fa = 24'($urandom); fb = ~fa;
    send_frame(fa);
    check("t3_kx_valid", kx_valid, 1);
    check("t3_kx_data", kx_data, fa);
    send_frame(fb);
    repeat (2) @(negedge clk);
    check("t3_overrun_pulses", n_ovr - o0, 1);
    check("t3_kx_data_held", kx_data, fa);
    check("t3_kx_valid_held", kx_valid, 1);
    kx_ready = 1'b1;
    push_exp(fa);
    wait_tx(2, 50, "t3_tx_wait");
    repeat (20) @(negedge clk);
    compare_tx("t3");
    check("t3_issued", kx_q.size(), 1);
    if (kx_q.size() > 0) check("t3_issued_data", kx_q[0], fa);

    // 4: partial frame timeout
    tx_q.delete(); exp_q.delete(); kx_q.delete(); ab0 = n_abort;
    send_byte(8'hA5); send_byte(8'h3C);
    repeat (TIMEOUT_CYC - 2) @(negedge clk);
    check("t4_no_early_abort", n_abort - ab0, 0);
    repeat (20) @(negedge clk);
    check("t4_abort_once", n_abort - ab0, 1);
    fc = 24'($urandom);
    push_exp(fc);
    send_frame(fc);
    check("t4_kx_data", kx_data, fc);
    wait_tx(2, 50, "t4_tx_wait");
    compare_tx("t4");

    // 5: reset in the middle of a transmission, with a partial frame pending
    tx_q.delete(); exp_q.delete();
    fa = 24'($urandom);
    send_frame(fa);
    send_byte(8'h77);
    cnt = 0;
    while (tx_q.size() < 1 && cnt < 50) begin @(negedge clk); cnt++; end
    check("t5_word0_sent", tx_q.size(), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("t5_rst");
    @(negedge clk);
    check("t5_no_word1", tx_q.size(), 1);
    rstn = 1'b1;
    tx_q.delete();
    @(negedge clk);
    fc = 24'($urandom);
    push_exp(fc);
    send_frame(fc);
    check("t5_kx_data", kx_data, fc);
    wait_tx(2, 50, "t5_tx_wait");
    compare_tx("t5");

    // 6: random frames with random inter-word gaps
    tx_q.delete(); exp_q.delete(); kx_q.delete(); fr_q.delete();
    o0 = n_ovr; ab0 = n_abort;
    for (int f = 0; f < 10; f++) begin
      fa = 24'($urandom);
      fr_q.push_back(fa);
      push_exp(fa);
      for (int i = 0; i < 3; i++) begin
        send_byte(fa[8*i +: 8]);
        repeat ($urandom_range(1, 100)) @(negedge clk);
      end
    end
    wait_tx(20, 500, "t6_tx_wait");
    compare_tx("t6");
    check("t6_issued", kx_q.size(), 10);
    for (int f = 0; f < 10; f++)
      if (f < kx_q.size()) check($sformatf("t6_kx_%0d", f), kx_q[f], fr_q[f]);
    check("t6_no_overrun", n_ovr - o0, 0);
    check("t6_no_abort", n_abort - ab0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
